// File: rtl/fp_alu_issue.sv
// Issue front-end for a combinational IEEE-754 single-precision ALU: command FIFO,
// registered operands held for a settle window, then captured onto a valid/ready output.
// Optional accumulated result flags: define FP_STICKY_FLAGS_EN.
module fp_alu_issue #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [31:0]                cmd_a,
  input  logic [31:0]                cmd_b,
  input  logic [2:0]                 cmd_op,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [2:0]                 alu_op,
  input  logic [31:0]                alu_result,
  input  logic                       alu_exception,
  input  logic                       alu_overflow,
  input  logic                       alu_underflow,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_data,
  output logic [2:0]                 res_flags,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [2:0]                 sticky_flags,
  input  logic                       sticky_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t          state, state_nx;
  logic [66:0]     mem [DEPTH];
  logic [66:0]     head;
  logic [AW-1:0]   wptr, rptr;
  logic [FW-1:0]   count;
  logic [CW-1:0]   cnt;
  logic            full, push, pop, head_illegal, settle_done, capture;
  logic [2:0]      cap_flags;

  assign full         = (count == FW'(DEPTH));
  assign cmd_ready    = !full;
  assign push         = cmd_valid && !full;
  assign pop          = (state == IDLE) && (count != '0);
  assign head         = mem[rptr];
  assign head_illegal = head[2];
  assign settle_done  = (state == SETTLE) && (cnt == '0);
  // Illegal opcodes bypass the ALU and complete on the pop edge itself.
  assign capture      = settle_done || (pop && head_illegal);
  assign cap_flags    = settle_done ? {alu_exception, alu_overflow, alu_underflow} : 3'b100;
  assign busy         = (state != IDLE) || (count != '0);
  assign fill         = count;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + FW'(1);
        2'b01:   count <= count - FW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pop) state_nx = head_illegal ? HOLD : SETTLE;
      SETTLE:  if (cnt == '0) state_nx = HOLD;
      HOLD:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
    end else begin
      if (pop) begin
        alu_a  <= head[66:35];
        alu_b  <= head[34:3];
        alu_op <= head[2:0];
        if (!head_illegal) cnt <= CW'(SETTLE_CYCLES - 1);
      end
      if ((state == SETTLE) && (cnt != '0)) cnt <= cnt - CW'(1);
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= settle_done ? alu_result : '0;
        res_flags <= cap_flags;
      end
      if ((state == HOLD) && res_ready) res_valid <= 1'b0;
    end
  end

`ifdef FP_STICKY_FLAGS_EN
  // Clear wins over the old contents but not over a flag captured on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sticky_flags <= '0;
    else if (sticky_clr) sticky_flags <= capture ? cap_flags : '0;
    else if (capture)    sticky_flags <= sticky_flags | cap_flags;
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = '0;
`endif

endmodule

// File: tb/tb_fp_alu_issue.sv
// Directed bench for fp_alu_issue with an XOR ALU stub: vector table plus
// backpressure, illegal-op ordering, sticky flags and mid-settle reset sequences.
module tb_fp_alu_issue;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_exception, alu_overflow, alu_underflow;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_flags, sticky_flags;
  logic        busy, sticky_clr;
  logic [2:0]  fill;

  int checks = 0;
  int failures = 0;

`ifdef FP_STICKY_FLAGS_EN
  localparam logic [2:0] EXP_DIV_STICKY = 3'b010;
`else
  localparam logic [2:0] EXP_DIV_STICKY = 3'b000;
`endif

  fp_alu_issue #(.DEPTH(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_exception(alu_exception),
    .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .busy(busy), .fill(fill),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
  );

  // ALU stub
  assign alu_result = alu_a ^ alu_b;
  assign {alu_exception, alu_overflow, alu_underflow} = (alu_op[1:0] == 2'b11) ? 3'b010 : 3'b000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] data;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] got_d [8];
  logic [2:0]  got_f [8];
  int          got_t [8];
  logic [31:0] bp_a [6];
  logic [31:0] bp_b [6];
  logic [2:0]  bp_op [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] stub_flags(input logic [2:0] op);
    if (op[2]) return 3'b100;
    return (op[1:0] == 2'b11) ? 3'b010 : 3'b000;
  endfunction

  function automatic logic [31:0] stub_data(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    return op[2] ? 32'h0 : (a ^ b);
  endfunction

  task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Single command into an empty idle block with res_ready held high.
  task automatic run_vec(input int i);
    int n;
    push1(vecs[i].a, vecs[i].b, vecs[i].op);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("v%0d_latency", i), n, vecs[i].lat);
    check($sformatf("v%0d_data", i), res_data, vecs[i].data);
    check($sformatf("v%0d_flags", i), res_flags, vecs[i].flags);
    check($sformatf("v%0d_busy_hold", i), busy, 1);
    tick();
    check($sformatf("v%0d_valid_drop", i), res_valid, 0);
    check($sformatf("v%0d_busy_idle", i), busy, 0);
  endtask

  task automatic collect(input int n);
    int k;
    k = 0;
    for (int c = 0; c < 200 && k < n; c++) begin
      tick();
      if (res_valid) begin
        got_d[k] = res_data;
        got_f[k] = res_flags;
        got_t[k] = c;
        k++;
      end
    end
    check("collect_count", k, n);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    res_ready = 1'b1; sticky_clr = 1'b0;

    vecs[0] = '{32'h411CCCCD, 32'h4089999A, 3'b000, 32'h01955557, 3'b000, 3};
    vecs[1] = '{32'hFFFF0000, 32'h0000FFFF, 3'b001, 32'hFFFFFFFF, 3'b000, 3};
    vecs[2] = '{32'h3F800000, 32'h40000000, 3'b010, 32'h7F800000, 3'b000, 3};
    vecs[3] = '{32'h12345678, 32'h12345678, 3'b011, 32'h00000000, 3'b010, 3};
    vecs[4] = '{32'h00000001, 32'h00000002, 3'b100, 32'h00000000, 3'b100, 1};
    vecs[5] = '{32'hDEADBEEF, 32'h01234567, 3'b111, 32'h00000000, 3'b100, 1};

    // Reset state
    tick(); tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_flags", res_flags, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_fill", fill, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_sticky", sticky_flags, 0);
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i);

    // Backpressure: c0 gets popped on the 2nd edge, so five pushes fill the FIFO.
    res_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bp_a[k]  = 32'h10000000 + 32'(k * 32'h01010101);
      bp_b[k]  = 32'h00F00000 + 32'(k);
      bp_op[k] = 3'(k % 4);
    end
    for (int k = 0; k < 5; k++) push1(bp_a[k], bp_b[k], bp_op[k]);
    check("bp_fill_full", fill, 4);
    check("bp_cmd_ready_full", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_a = bp_a[5]; cmd_b = bp_b[5]; cmd_op = bp_op[5];
    for (int c = 0; c < 4; c++) begin
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_data", res_data, stub_data(bp_a[0], bp_b[0], bp_op[0]));
      check("bp_hold_fill", fill, 4);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("bp_hs_valid", res_valid, 0);
    check("bp_hs_fill", fill, 4);
    check("bp_hs_cmd_ready", cmd_ready, 0);
    tick();
    check("bp_pop_no_push_fill", fill, 3);
    tick();
    check("bp_late_push_fill", fill, 4);
    cmd_valid = 1'b0;
    collect(5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_order_data%0d", k + 1), got_d[k], stub_data(bp_a[k+1], bp_b[k+1], bp_op[k+1]));
      check($sformatf("bp_order_flags%0d", k + 1), got_f[k], stub_flags(bp_op[k+1]));
    end
    tick(); tick();
    check("bp_drained_busy", busy, 0);

    // Illegal op between two adds
    cmd_valid = 1'b1; cmd_a = 32'h3F800000; cmd_b = 32'h3F000000; cmd_op = 3'b000; tick();
    cmd_a = 32'hAAAA5555; cmd_b = 32'h12345678; cmd_op = 3'b101; tick();
    cmd_a = 32'h40490FDB; cmd_b = 32'hC0000000; cmd_op = 3'b000; tick();
    cmd_valid = 1'b0;
    collect(3);
    check("ill_r0_data", got_d[0], 32'h00800000);
    check("ill_r0_flags", got_f[0], 3'b000);
    check("ill_r1_data", got_d[1], 32'h0);
    check("ill_r1_flags", got_f[1], 3'b100);
    check("ill_r2_data", got_d[2], 32'h80490FDB);
    check("ill_r2_flags", got_f[2], 3'b000);
    check("ill_gap_illegal", got_t[1] - got_t[0], 2);
    check("ill_gap_legal", got_t[2] - got_t[1], 4);
    tick(); tick();

    // Sticky flags
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("sticky_cleared0", sticky_flags, 0);
    run_vec(3);
    check("sticky_after_div", sticky_flags, EXP_DIV_STICKY);
    run_vec(0);
    check("sticky_after_add", sticky_flags, EXP_DIV_STICKY);
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("sticky_cleared1", sticky_flags, 0);

    // Reset while settling with two commands queued
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 32'h1; cmd_b = 32'h2; cmd_op = 3'b100; tick();
    cmd_a = 32'h11; cmd_op = 3'b000; tick();
    cmd_a = 32'h22; tick();
    cmd_a = 32'h33; tick();
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick(); tick();
    check("rs_pre_fill", fill, 2);
    check("rs_pre_alu_a", alu_a, 32'h11);
    rst_n = 1'b0;
    #1;
    check("rs_valid", res_valid, 0);
    check("rs_fill", fill, 0);
    check("rs_cmd_ready", cmd_ready, 1);
    check("rs_busy", busy, 0);
    check("rs_alu_a", alu_a, 0);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (res_valid) seen++;
    end
    check("rs_no_stale_result", seen, 0);
    check("rs_post_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
